// File: rtl/store_queue_pkg.sv
// Shared types and sizes for the store queue.
package store_queue_pkg;
   localparam int SQ_SZ  = 8;
   localparam int N_DISP = 3;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ROB_W  = 5;

   typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD, MEM_DOUBLE} mem_size_t;

   // Slot index and pointer (index plus wrap bit) for the default depth.
   typedef logic [$clog2(SQ_SZ)-1:0] sq_idx_t;
   typedef logic [$clog2(SQ_SZ):0]   sq_ptr_t;

   typedef struct packed {
      logic              valid;
      logic              executed;
      logic [ROB_W-1:0]  rob_idx;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      mem_size_t         size;
   } sq_entry_t;
endpackage

// File: rtl/store_queue_fwd.sv
// Age-ordered store-to-load forwarding search over the candidate window
// [head, fwd_tail). Entries are visited oldest first so the youngest
// decisive entry is the one left standing in the flags.
module store_queue_fwd
   import store_queue_pkg::*;
#(
   parameter  int SQ_DEPTH = SQ_SZ,
   localparam int IDX_W    = $clog2(SQ_DEPTH),
   localparam int PTR_W    = IDX_W + 1
) (
   input  sq_entry_t         entries [SQ_DEPTH],
   input  logic [PTR_W-1:0]  head,
   input  logic [PTR_W-1:0]  fwd_tail,
   input  logic              fwd_valid,
   input  logic [ADDR_W-1:0] fwd_addr,
   input  mem_size_t         fwd_size,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data,
   output logic              fwd_stall
);
   logic [PTR_W-1:0] n_cand;
   sq_entry_t        e;

   // Later (younger) decisive entries overwrite earlier results.
   always_comb begin
      fwd_hit   = 1'b0;
      fwd_stall = 1'b0;
      fwd_data  = '0;
      e         = '0;
      n_cand    = fwd_tail - head;
      if (fwd_valid) begin
         for (int k = 0; k < SQ_DEPTH; k++) begin
            e = entries[head[IDX_W-1:0] + IDX_W'(k)];
            if (PTR_W'(k) < n_cand && e.valid) begin
               if (!e.executed) begin
                  fwd_hit   = 1'b0;
                  fwd_stall = 1'b1;
                  fwd_data  = '0;
               end else if (e.addr[ADDR_W-1:2] == fwd_addr[ADDR_W-1:2]) begin
                  if (e.size == fwd_size && e.addr == fwd_addr) begin
                     fwd_hit   = 1'b1;
                     fwd_stall = 1'b0;
                     fwd_data  = e.data;
                  end else begin
                     fwd_hit   = 1'b0;
                     fwd_stall = 1'b1;
                     fwd_data  = '0;
                  end
               end
            end
         end
      end
   end
endmodule

// File: rtl/store_queue.sv
// Circular store queue: in-order allocate at dispatch, fill at execute,
// drain from head at retire, full flush on mispredict.
module store_queue
   import store_queue_pkg::*;
#(
   parameter  int SQ_DEPTH = SQ_SZ,
   parameter  int N        = N_DISP,
   localparam int IDX_W    = $clog2(SQ_DEPTH),
   localparam int PTR_W    = IDX_W + 1,
   localparam int CNT_W    = $clog2(SQ_DEPTH + 1),
   localparam int FC_W     = $clog2(N + 1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [N-1:0]               disp_valid,
   input  logic [N-1:0][ROB_W-1:0]    disp_rob_idx,
   output logic [N-1:0][IDX_W-1:0]    disp_sq_idx,
   output logic [CNT_W-1:0]           free_slots,
   input  logic                       ex_valid,
   input  logic [IDX_W-1:0]           ex_sq_idx,
   input  logic [ADDR_W-1:0]          ex_addr,
   input  logic [DATA_W-1:0]          ex_data,
   input  mem_size_t                  ex_size,
   output logic                       sq_head_valid,
   output logic [ADDR_W-1:0]          head_addr,
   output logic [DATA_W-1:0]          head_data,
   output mem_size_t                  head_size,
   input  logic [FC_W-1:0]            sq_free_count,
   input  logic                       mispredict,
   input  logic                       fwd_valid,
   input  logic [ADDR_W-1:0]          fwd_addr,
   input  mem_size_t                  fwd_size,
   input  logic [PTR_W-1:0]           fwd_tail,
   output logic                       fwd_hit,
   output logic [DATA_W-1:0]          fwd_data,
   output logic                       fwd_stall
);
   sq_entry_t        entries_q [SQ_DEPTH];
   sq_entry_t        entries_d [SQ_DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count;
   logic [FC_W-1:0]  n_disp;
   logic             disp_ok, free_ok;
   sq_entry_t        head_e;

   // Pointer distance is the occupancy; the wrap bit makes full distinct from empty.
   assign count      = CNT_W'(tail_q - head_q);
   assign free_slots = CNT_W'(SQ_DEPTH) - count;
   assign disp_ok    = CNT_W'(n_disp) <= free_slots;
   assign free_ok    = CNT_W'(sq_free_count) <= count;

   // Asserted lanes take consecutive slots from tail in lane order.
   always_comb begin
      n_disp = '0;
      for (int i = 0; i < N; i++) begin
         disp_sq_idx[i] = '0;
         if (disp_valid[i]) begin
            disp_sq_idx[i] = tail_q[IDX_W-1:0] + IDX_W'(n_disp);
            n_disp         = n_disp + FC_W'(1);
         end
      end
   end

   // Next state: mispredict overrides everything; otherwise execute, retire and
   // dispatch touch distinct slots and all land on the same edge.
   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      if (mispredict) begin
         for (int k = 0; k < SQ_DEPTH; k++) begin
            entries_d[k].valid    = 1'b0;
            entries_d[k].executed = 1'b0;
         end
         head_d = '0;
         tail_d = '0;
      end else begin
         if (ex_valid && entries_q[ex_sq_idx].valid) begin
            entries_d[ex_sq_idx].addr     = ex_addr;
            entries_d[ex_sq_idx].data     = ex_data;
            entries_d[ex_sq_idx].size     = ex_size;
            entries_d[ex_sq_idx].executed = 1'b1;
         end
         if (free_ok) begin
            for (int k = 0; k < N; k++) begin
               if (FC_W'(k) < sq_free_count) begin
                  entries_d[head_q[IDX_W-1:0] + IDX_W'(k)].valid    = 1'b0;
                  entries_d[head_q[IDX_W-1:0] + IDX_W'(k)].executed = 1'b0;
               end
            end
            head_d = head_q + PTR_W'(sq_free_count);
         end
         if (disp_ok) begin
            for (int i = 0; i < N; i++) begin
               if (disp_valid[i]) begin
                  entries_d[disp_sq_idx[i]] = '{valid: 1'b1, executed: 1'b0,
                                                rob_idx: disp_rob_idx[i],
                                                addr: '0, data: '0, size: MEM_BYTE};
               end
            end
            tail_d = tail_q + PTR_W'(n_disp);
         end
      end
   end

   // State registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < SQ_DEPTH; k++) entries_q[k] <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
      end
   end

   // Over-allocation and over-retire are caller bugs.
   a_disp_fits: assert property (@(posedge clock) disable iff (reset) disp_ok);
   a_free_fits: assert property (@(posedge clock) disable iff (reset) free_ok);

   assign head_e        = entries_q[head_q[IDX_W-1:0]];
   assign sq_head_valid = head_e.valid & head_e.executed;
   assign head_addr     = head_e.addr;
   assign head_data     = head_e.data;
   assign head_size     = head_e.size;

   store_queue_fwd #(.SQ_DEPTH(SQ_DEPTH)) u_fwd (
      .entries   (entries_q),
      .head      (head_q),
      .fwd_tail  (fwd_tail),
      .fwd_valid (fwd_valid),
      .fwd_addr  (fwd_addr),
      .fwd_size  (fwd_size),
      .fwd_hit   (fwd_hit),
      .fwd_data  (fwd_data),
      .fwd_stall (fwd_stall)
   );
endmodule

// File: tb/tb_store_queue.sv
// Directed scenarios then random traffic, checked every cycle against a
// queue-based model of the store queue.
module tb_store_queue;
   import store_queue_pkg::*;
   localparam int D  = 8;
   localparam int NL = 3;

   logic                   clock = 1'b0;
   logic                   reset;
   logic [NL-1:0]          disp_valid;
   logic [NL-1:0][ROB_W-1:0] disp_rob_idx;
   logic [NL-1:0][2:0]     disp_sq_idx;
   logic [3:0]             free_slots;
   logic                   ex_valid;
   logic [2:0]             ex_sq_idx;
   logic [31:0]            ex_addr, ex_data;
   mem_size_t              ex_size;
   logic                   sq_head_valid;
   logic [31:0]            head_addr, head_data;
   mem_size_t              head_size;
   logic [1:0]             sq_free_count;
   logic                   mispredict, fwd_valid;
   logic [31:0]            fwd_addr;
   mem_size_t              fwd_size;
   logic [3:0]             fwd_tail;
   logic                   fwd_hit, fwd_stall;
   logic [31:0]            fwd_data;

   always #5 clock = ~clock;

   store_queue #(.SQ_DEPTH(D), .N(NL)) dut (
      .clock(clock), .reset(reset),
      .disp_valid(disp_valid), .disp_rob_idx(disp_rob_idx), .disp_sq_idx(disp_sq_idx),
      .free_slots(free_slots),
      .ex_valid(ex_valid), .ex_sq_idx(ex_sq_idx), .ex_addr(ex_addr), .ex_data(ex_data),
      .ex_size(ex_size),
      .sq_head_valid(sq_head_valid), .head_addr(head_addr), .head_data(head_data),
      .head_size(head_size),
      .sq_free_count(sq_free_count), .mispredict(mispredict),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_size(fwd_size), .fwd_tail(fwd_tail),
      .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
   );

   typedef struct {
      int          slot;
      bit          exec;
      logic [31:0] addr;
      logic [31:0] data;
      mem_size_t   size;
   } ment_t;

   ment_t mq[$];
   int    mhead, mtail;
   int    checks, failures;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      disp_valid = '0; disp_rob_idx = '0;
      ex_valid = 1'b0; ex_sq_idx = '0; ex_addr = '0; ex_data = '0; ex_size = MEM_BYTE;
      sq_free_count = '0; mispredict = 1'b0;
      fwd_valid = 1'b0; fwd_addr = '0; fwd_size = MEM_BYTE; fwd_tail = '0;
   endtask

   // Check all outputs against the model for the current inputs, then clock
   // the model forward by one edge. Called just after a negedge.
   task automatic cycle();
      int off, m;
      bit ehit, estall;
      logic [31:0] edata;
      bit hv;
      #1;
      off = 0;
      for (int i = 0; i < NL; i++) begin
         if (disp_valid[i]) begin
            chk($sformatf("disp_sq_idx%0d", i), 64'(disp_sq_idx[i]), 64'((mtail + off) % D));
            off++;
         end else begin
            chk($sformatf("disp_sq_idx%0d_idle", i), 64'(disp_sq_idx[i]), 64'(0));
         end
      end
      chk("free_slots", 64'(free_slots), 64'(D - mq.size()));
      hv = (mq.size() > 0) ? mq[0].exec : 1'b0;
      chk("sq_head_valid", 64'(sq_head_valid), 64'(hv));
      if (hv) begin
         chk("head_addr", 64'(head_addr), 64'(mq[0].addr));
         chk("head_data", 64'(head_data), 64'(mq[0].data));
         chk("head_size", 64'(head_size), 64'(mq[0].size));
      end
      ehit = 1'b0; estall = 1'b0; edata = '0;
      if (fwd_valid) begin
         m = (int'(fwd_tail) - mhead + 2 * D) % (2 * D);
         for (int k = m - 1; k >= 0; k--) begin
            if (!mq[k].exec) begin estall = 1'b1; break; end
            if (mq[k].addr[31:2] == fwd_addr[31:2]) begin
               if (mq[k].size == fwd_size && mq[k].addr == fwd_addr) begin
                  ehit = 1'b1; edata = mq[k].data;
               end else begin
                  estall = 1'b1;
               end
               break;
            end
         end
      end
      chk("fwd_hit", 64'(fwd_hit), 64'(ehit));
      chk("fwd_stall", 64'(fwd_stall), 64'(estall));
      if (ehit) chk("fwd_data", 64'(fwd_data), 64'(edata));
      @(posedge clock);
      if (mispredict) begin
         mq.delete(); mhead = 0; mtail = 0;
      end else begin
         if (ex_valid) begin
            foreach (mq[j]) begin
               if (mq[j].slot == int'(ex_sq_idx)) begin
                  mq[j].exec = 1'b1; mq[j].addr = ex_addr;
                  mq[j].data = ex_data; mq[j].size = ex_size;
               end
            end
         end
         for (int k = 0; k < int'(sq_free_count); k++) void'(mq.pop_front());
         mhead = (mhead + int'(sq_free_count)) % (2 * D);
         for (int i = 0; i < NL; i++) begin
            if (disp_valid[i]) begin
               mq.push_back('{slot: mtail % D, exec: 1'b0, addr: '0, data: '0, size: MEM_BYTE});
               mtail = (mtail + 1) % (2 * D);
            end
         end
      end
      @(negedge clock);
   endtask

   task automatic exec_slot(input int s, input logic [31:0] a, input logic [31:0] d, input mem_size_t sz);
      idle_inputs();
      ex_valid = 1'b1; ex_sq_idx = 3'(s); ex_addr = a; ex_data = d; ex_size = sz;
      cycle();
      idle_inputs();
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] base;
      case ($urandom_range(0, 2))
         0:       base = 32'h200;
         1:       base = 32'h204;
         default: base = 32'h300;
      endcase
      return base + 32'($urandom_range(0, 3));
   endfunction

   initial begin
      int dv, lead, fc, j;
      checks = 0; failures = 0; mhead = 0; mtail = 0;
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      chk("rst_free_slots", 64'(free_slots), 64'(8));
      chk("rst_head_valid", 64'(sq_head_valid), 64'(0));
      chk("rst_head_addr", 64'(head_addr), 64'(0));
      chk("rst_head_data", 64'(head_data), 64'(0));
      chk("rst_head_size", 64'(head_size), 64'(0));
      chk("rst_fwd_hit", 64'(fwd_hit), 64'(0));
      chk("rst_fwd_stall", 64'(fwd_stall), 64'(0));
      chk("rst_fwd_data", 64'(fwd_data), 64'(0));
      chk("rst_disp_sq_idx", 64'(disp_sq_idx), 64'(0));
      @(negedge clock);
      reset = 1'b0;

      // Two stores on lanes 0 and 1.
      disp_valid = 3'b011; disp_rob_idx = 15'($urandom);
      #1;
      chk("t1_idx0", 64'(disp_sq_idx[0]), 64'(0));
      chk("t1_idx1", 64'(disp_sq_idx[1]), 64'(1));
      cycle(); idle_inputs();
      #1;
      chk("t1_free", 64'(free_slots), 64'(6));
      chk("t1_hv", 64'(sq_head_valid), 64'(0));

      // Execute slot 0, see it at head, retire it.
      exec_slot(0, 32'h100, 32'hDEAD, MEM_WORD);
      #1;
      chk("t2_hv", 64'(sq_head_valid), 64'(1));
      chk("t2_haddr", 64'(head_addr), 64'(32'h100));
      sq_free_count = 2'd1;
      cycle(); idle_inputs();
      #1;
      chk("t2_hv_after_retire", 64'(sq_head_valid), 64'(0));

      // Flush, fill to 8, retire 3, dispatch 3 across the wrap.
      mispredict = 1'b1; cycle(); idle_inputs();
      disp_valid = 3'b111; cycle();
      disp_valid = 3'b111; cycle();
      disp_valid = 3'b011;
      #1;
      chk("t3_idx6", 64'(disp_sq_idx[0]), 64'(6));
      chk("t3_idx7", 64'(disp_sq_idx[1]), 64'(7));
      cycle(); idle_inputs();
      #1;
      chk("t3_full", 64'(free_slots), 64'(0));
      for (int s = 0; s < 3; s++) exec_slot(s, 32'h500 + 32'(4 * s), 32'(s), MEM_WORD);
      sq_free_count = 2'd3; cycle(); idle_inputs();
      #1;
      chk("t3_free3", 64'(free_slots), 64'(3));
      disp_valid = 3'b111;
      #1;
      chk("t3_wrap_idx0", 64'(disp_sq_idx[0]), 64'(0));
      chk("t3_wrap_idx2", 64'(disp_sq_idx[2]), 64'(2));
      cycle(); idle_inputs();
      #1;
      chk("t3_full_again", 64'(free_slots), 64'(0));
      fwd_valid = 1'b1; fwd_addr = 32'h500; fwd_size = MEM_WORD; fwd_tail = 4'b1011;
      #1;
      chk("t3_fwd_stall", 64'(fwd_stall), 64'(1));
      cycle(); idle_inputs();

      // Forwarding from the youngest matching older store.
      mispredict = 1'b1; cycle(); idle_inputs();
      disp_valid = 3'b011; cycle(); idle_inputs();
      exec_slot(0, 32'h200, 32'h11, MEM_WORD);
      exec_slot(1, 32'h200, 32'h22, MEM_WORD);
      fwd_valid = 1'b1; fwd_addr = 32'h200; fwd_size = MEM_WORD; fwd_tail = 4'd2;
      #1;
      chk("t4_hit_young", 64'(fwd_hit), 64'(1));
      chk("t4_data_young", 64'(fwd_data), 64'(32'h22));
      cycle();
      fwd_tail = 4'd1;
      #1;
      chk("t4_hit_old", 64'(fwd_hit), 64'(1));
      chk("t4_data_old", 64'(fwd_data), 64'(32'h11));
      cycle(); idle_inputs();

      // Unexecuted older store, then partial overlap, then a miss.
      disp_valid = 3'b001; cycle(); idle_inputs();
      fwd_valid = 1'b1; fwd_addr = 32'h999; fwd_size = MEM_BYTE; fwd_tail = 4'd3;
      #1;
      chk("t5_stall_unexec", 64'(fwd_stall), 64'(1));
      cycle(); idle_inputs();
      exec_slot(2, 32'h300, 32'hCAFE, MEM_WORD);
      fwd_valid = 1'b1; fwd_addr = 32'h301; fwd_size = MEM_BYTE; fwd_tail = 4'd3;
      #1;
      chk("t5_stall_partial", 64'(fwd_stall), 64'(1));
      chk("t5_nohit_partial", 64'(fwd_hit), 64'(0));
      cycle();
      fwd_addr = 32'h400;
      #1;
      chk("t5_miss_stall", 64'(fwd_stall), 64'(0));
      chk("t5_miss_hit", 64'(fwd_hit), 64'(0));
      cycle(); idle_inputs();

      // Mispredict with 5 entries plus same-cycle dispatch and execute.
      disp_valid = 3'b011; cycle(); idle_inputs();
      mispredict = 1'b1; disp_valid = 3'b001;
      ex_valid = 1'b1; ex_sq_idx = 3'd3; ex_addr = 32'h700; ex_data = 32'h77; ex_size = MEM_WORD;
      cycle(); idle_inputs();
      #1;
      chk("t6_free", 64'(free_slots), 64'(8));
      chk("t6_hv", 64'(sq_head_valid), 64'(0));

      // Random traffic.
      for (int it = 0; it < 600; it++) begin
         idle_inputs();
         dv = int'($urandom_range(0, 7));
         if ($countones(3'(dv)) > D - mq.size()) dv = 0;
         disp_valid = 3'(dv);
         disp_rob_idx = 15'($urandom);
         lead = 0;
         while (lead < mq.size() && mq[lead].exec) lead++;
         fc = int'($urandom_range(0, (lead < 3) ? lead : 3));
         sq_free_count = 2'(fc);
         if (mq.size() > fc && $urandom_range(0, 3) != 0) begin
            j = int'($urandom_range(fc, mq.size() - 1));
            ex_valid = 1'($urandom_range(0, 1));
            ex_sq_idx = 3'(mq[j].slot);
         end else if (mq.size() < D) begin
            ex_valid = 1'($urandom_range(0, 1));
            ex_sq_idx = 3'(mtail % D);
         end
         ex_addr = rand_addr(); ex_data = $urandom; ex_size = mem_size_t'($urandom_range(0, 2));
         fwd_valid = 1'($urandom_range(0, 1));
         fwd_tail = 4'((mhead + int'($urandom_range(0, mq.size()))) % (2 * D));
         fwd_addr = rand_addr(); fwd_size = mem_size_t'($urandom_range(0, 2));
         mispredict = ($urandom_range(0, 24) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
